// File: rtl/mem_ctl_pkg.sv
// Shared types and request-field layout for the core memory request sequencer.
package mem_ctl_pkg;

  localparam int RQ_W        = 65;
  localparam int RQ_ADDR_MSB = 64;
  localparam int RQ_ADDR_LSB = 33;
  localparam int RQ_WE       = 32;
  localparam int RQ_DATA_MSB = 31;

  typedef enum logic [2:0] {
    IDLE,
    RAM_RD,
    MMIO_REQ,
    MMIO_RSP,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_t;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational byte-address to region decode; RAM wins where it overlaps the MMIO window.
module mem_region_decode
  import mem_ctl_pkg::*;
#(
  parameter int          LGSZW     = 8,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int          MMIO_LGSZ = 12
) (
  input  logic [31:0] addr,
  output region_t     region
);

  logic [31:0] ram_hi;
  logic [31:0] mmio_hi;
  logic [31:0] base_hi;

  always_comb begin
    ram_hi  = addr >> (2 + LGSZW);
    mmio_hi = addr >> MMIO_LGSZ;
    base_hi = MMIO_BASE >> MMIO_LGSZ;
    if (ram_hi == 32'd0) begin
      region = REG_RAM;
    end else if (mmio_hi == base_hi) begin
      region = REG_MMIO;
    end else begin
      region = REG_NONE;
    end
  end

endmodule

// File: rtl/mem_rq_sequencer.sv
// Accepts one core memory request at a time, steers it to RAM or the MMIO port,
// and returns exactly one response per request under response backpressure.
module mem_rq_sequencer
  import mem_ctl_pkg::*;
#(
  parameter int          LGSZW       = 8,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter int          MMIO_LGSZ   = 12,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             rst_n,
  // Both the core get/put pair and the MMIO port use the same rule: a transfer
  // happens on a clock edge where the offering side's valid/rdy and the taking
  // side's ready/en are both high; an offered payload stays stable until then.
  input  logic             rq_rdy,
  output logic             rq_en,
  input  logic [RQ_W-1:0]  rq_data,
  input  logic             rs_rdy,
  output logic             rs_en,
  output logic [31:0]      rs_data,
  output logic [LGSZW-1:0] ram_addr,
  output logic             ram_we,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata,
  output logic             mmio_req_valid,
  input  logic             mmio_req_ready,
  output logic [31:0]      mmio_req_addr,
  output logic             mmio_req_we,
  output logic [31:0]      mmio_req_wdata,
  input  logic             mmio_rsp_valid,
  input  logic [31:0]      mmio_rsp_data,
  output logic             busy,
  output logic             err,
  output state_t           dbg_state
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  region_t     rq_region;
  logic [31:0] rq_addr;
  logic        rq_we;
  logic        we_q;
  logic [31:0] rsp_q;
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic [31:0] ram_rsp;

  assign rq_addr = rq_data[RQ_ADDR_MSB:RQ_ADDR_LSB];
  assign rq_we   = rq_data[RQ_WE];

  mem_region_decode #(
    .LGSZW     (LGSZW),
    .MMIO_BASE (MMIO_BASE),
    .MMIO_LGSZ (MMIO_LGSZ)
  ) u_decode (
    .addr   (rq_addr),
    .region (rq_region)
  );

  assign rq_en     = rq_rdy && (state == IDLE);
  assign ram_addr  = rq_addr[LGSZW+1:2];
  assign ram_wdata = rq_data[RQ_DATA_MSB:0];
  assign ram_we    = rq_en && (rq_region == REG_RAM) && rq_we;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // The counter holds the index of the current cycle spent in the MMIO states,
  // so the last allowed cycle is TIMEOUT_CYC-1; >= covers a late MMIO accept.
  assign tmo_hit = (tmo_cnt >= TMO_LAST);
  assign ram_rsp = we_q ? 32'd0 : ram_rdata;
  assign rs_en   = rs_rdy && ((state == RAM_RD) || (state == RESP));

  always_comb begin
    rs_data = 32'd0;
    case (state)
      RAM_RD:  rs_data = ram_rsp;
      RESP:    rs_data = rsp_q;
      default: rs_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      rsp_q          <= 32'd0;
      tmo_cnt        <= 16'd0;
      err            <= 1'b0;
      mmio_req_valid <= 1'b0;
      mmio_req_addr  <= 32'd0;
      mmio_req_we    <= 1'b0;
      mmio_req_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rq_en) begin
            we_q <= rq_we;
            case (rq_region)
              REG_RAM: state <= RAM_RD;
              REG_MMIO: begin
                state          <= MMIO_REQ;
                mmio_req_valid <= 1'b1;
                mmio_req_addr  <= rq_addr;
                mmio_req_we    <= rq_we;
                mmio_req_wdata <= rq_data[RQ_DATA_MSB:0];
                tmo_cnt        <= 16'd0;
              end
              default: begin
                state <= RESP;
                rsp_q <= ERR_DATA;
                err   <= 1'b1;
              end
            endcase
          end
        end
        RAM_RD: begin
          if (rs_rdy) begin
            state <= IDLE;
          end else begin
            rsp_q <= ram_rsp;
            state <= RESP;
          end
        end
        MMIO_REQ: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (mmio_req_ready) begin
            mmio_req_valid <= 1'b0;
            state          <= MMIO_RSP;
          end else if (tmo_hit) begin
            mmio_req_valid <= 1'b0;
            rsp_q          <= ERR_DATA;
            err            <= 1'b1;
            state          <= RESP;
          end
        end
        MMIO_RSP: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (mmio_rsp_valid) begin
            rsp_q <= mmio_req_we ? 32'd0 : mmio_rsp_data;
            state <= RESP;
          end else if (tmo_hit) begin
            rsp_q <= ERR_DATA;
            err   <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          if (rs_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rq_sequencer.sv
// Self-checking bench for mem_rq_sequencer: directed scenarios plus a randomized
// mix checked against a request-level memory/region model.
module tb_mem_rq_sequencer;

  localparam int TMO = 255;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        rq_rdy;
  logic        rq_en;
  logic [64:0] rq_data;
  logic        rs_rdy;
  logic        rs_en;
  logic [31:0] rs_data;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        mmio_req_valid;
  logic        mmio_req_ready;
  logic [31:0] mmio_req_addr;
  logic        mmio_req_we;
  logic [31:0] mmio_req_wdata;
  logic        mmio_rsp_valid;
  logic [31:0] mmio_rsp_data;
  logic        busy;
  logic        err;
  mem_ctl_pkg::state_t dbg_state;

  int total = 0;
  int bad = 0;
  int n_rq = 0;
  int n_rs = 0;
  int dropped = 0;
  logic exp_err = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] ram[256];
  logic [31:0] ref_mem[256];

  mem_rq_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rq_rdy         (rq_rdy),
    .rq_en          (rq_en),
    .rq_data        (rq_data),
    .rs_rdy         (rs_rdy),
    .rs_en          (rs_en),
    .rs_data        (rs_data),
    .ram_addr       (ram_addr),
    .ram_we         (ram_we),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .mmio_req_valid (mmio_req_valid),
    .mmio_req_ready (mmio_req_ready),
    .mmio_req_addr  (mmio_req_addr),
    .mmio_req_we    (mmio_req_we),
    .mmio_req_wdata (mmio_req_wdata),
    .mmio_rsp_valid (mmio_rsp_valid),
    .mmio_rsp_data  (mmio_rsp_data),
    .busy           (busy),
    .err            (err),
    .dbg_state      (dbg_state)
  );

  // clock / reset / environment
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (rq_en) n_rq++;
      if (rs_en) n_rs++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // reference model: region from address arithmetic, RAM as a word array
  task automatic model_rq(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [31:0] md, output logic [31:0] e, output int k);
    if (a < 32'h400) begin
      k = 0;
      if (w) begin
        ref_mem[a[9:2]] = d;
        e = 32'd0;
      end else begin
        e = ref_mem[a[9:2]];
      end
    end else if (a >= 32'h1000_0000 && a < 32'h1000_1000) begin
      k = 1;
      e = w ? 32'd0 : md;
    end else begin
      k = 2;
      e = ERRD;
      exp_err = 1'b1;
    end
  endtask

  // drivers
  task automatic send_rq(input logic [31:0] a, input logic w, input logic [31:0] d,
                         output logic en, output logic we_o, output logic [7:0] ad_o,
                         output logic mv);
    @(negedge clk);
    rq_rdy = 1'b1;
    rq_data = {a, w, d};
    #1;
    en = rq_en;
    we_o = ram_we;
    ad_o = ram_addr;
    @(negedge clk);
    rq_rdy = 1'b0;
    mv = mmio_req_valid;
  endtask

  task automatic wait_rsp(input int max, output logic got, output logic [31:0] data,
                          output int lat);
    got = 1'b0;
    data = 32'd0;
    lat = -1;
    for (int i = 0; i < max && !got; i++) begin
      #1;
      if (rs_en) begin
        got = 1'b1;
        data = rs_data;
        lat = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (rq_en !== 1'b0) begin bad++; $display("FAIL reset_rq_en got=%b exp=0", rq_en); end
    total++; if (rs_en !== 1'b0) begin bad++; $display("FAIL reset_rs_en got=%b exp=0", rs_en); end
    total++; if (rs_data !== 32'd0) begin bad++; $display("FAIL reset_rs_data got=%h exp=0", rs_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (mmio_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mmio_valid got=%b exp=0", mmio_req_valid); end
    total++; if (mmio_req_addr !== 32'd0) begin bad++; $display("FAIL reset_mmio_addr got=%h exp=0", mmio_req_addr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram_wr_rd;
    logic en, we_o, mv, got;
    logic [7:0] ad;
    logic [31:0] e, data;
    int k, lat;
    model_rq(32'h10, 1'b1, 32'h1234_5678, 32'd0, e, k);
    send_rq(32'h10, 1'b1, 32'h1234_5678, en, we_o, ad, mv);
    total++; if (en !== 1'b1) begin bad++; $display("FAIL ramwr_rq_en got=%b exp=1", en); end
    total++; if (we_o !== 1'b1) begin bad++; $display("FAIL ramwr_ram_we got=%b exp=1", we_o); end
    total++; if (ad !== 8'd4) begin bad++; $display("FAIL ramwr_ram_addr got=%0d exp=4", ad); end
    wait_rsp(8, got, data, lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL ramwr_latency got=%0d exp=0", lat); end
    total++; if (data !== e) begin bad++; $display("FAIL ramwr_data got=%h exp=%h", data, e); end
    model_rq(32'h10, 1'b0, 32'd0, 32'd0, e, k);
    send_rq(32'h10, 1'b0, 32'd0, en, we_o, ad, mv);
    total++; if (we_o !== 1'b0) begin bad++; $display("FAIL ramrd_ram_we got=%b exp=0", we_o); end
    wait_rsp(8, got, data, lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL ramrd_latency got=%0d exp=0", lat); end
    total++; if (data !== e) begin bad++; $display("FAIL ramrd_data got=%h exp=%h", data, e); end
  endtask

  task automatic test_backpressure;
    logic en, we_o, mv;
    logic [7:0] ad;
    logic [31:0] e;
    int k;
    rs_rdy = 1'b0;
    model_rq(32'h10, 1'b0, 32'd0, 32'd0, e, k);
    send_rq(32'h10, 1'b0, 32'd0, en, we_o, ad, mv);
    rq_rdy = 1'b1;
    rq_data = {32'h14, 1'b0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (rs_en !== 1'b0) begin bad++; $display("FAIL bp_rs_en cyc=%0d got=%b exp=0", i, rs_en); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy cyc=%0d got=%b exp=1", i, busy); end
      total++; if (rq_en !== 1'b0) begin bad++; $display("FAIL bp_rq_en cyc=%0d got=%b exp=0", i, rq_en); end
      @(negedge clk);
    end
    rq_rdy = 1'b0;
    rs_rdy = 1'b1;
    #1;
    total++; if (rs_en !== 1'b1) begin bad++; $display("FAIL bp_release_rs_en got=%b exp=1", rs_en); end
    total++; if (rs_data !== e) begin bad++; $display("FAIL bp_release_data got=%h exp=%h", rs_data, e); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] ea, eb;
    int k;
    model_rq(32'h10, 1'b0, 32'd0, 32'd0, ea, k);
    model_rq(32'h20, 1'b1, 32'hA5A5_0001, 32'd0, eb, k);
    @(negedge clk);
    rq_rdy = 1'b1;
    rq_data = {32'h10, 1'b0, 32'd0};
    #1;
    total++; if (rq_en !== 1'b1) begin bad++; $display("FAIL b2b_first_rq_en got=%b exp=1", rq_en); end
    @(negedge clk);
    rq_data = {32'h20, 1'b1, 32'hA5A5_0001};
    #1;
    total++; if (rs_en !== 1'b1) begin bad++; $display("FAIL b2b_first_rs_en got=%b exp=1", rs_en); end
    total++; if (rs_data !== ea) begin bad++; $display("FAIL b2b_first_data got=%h exp=%h", rs_data, ea); end
    total++; if (rq_en !== 1'b0) begin bad++; $display("FAIL b2b_rq_en_with_rs_en got=%b exp=0", rq_en); end
    @(negedge clk);
    #1;
    total++; if (rq_en !== 1'b1) begin bad++; $display("FAIL b2b_second_rq_en got=%b exp=1", rq_en); end
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL b2b_second_ram_we got=%b exp=1", ram_we); end
    @(negedge clk);
    rq_rdy = 1'b0;
    #1;
    total++; if (rs_en !== 1'b1) begin bad++; $display("FAIL b2b_second_rs_en got=%b exp=1", rs_en); end
    total++; if (rs_data !== eb) begin bad++; $display("FAIL b2b_second_data got=%h exp=%h", rs_data, eb); end
    @(negedge clk);
  endtask

  task automatic test_mmio_read;
    logic en, we_o, mv, got;
    logic [7:0] ad;
    logic [31:0] e, data;
    int k, lat;
    model_rq(32'h1000_0004, 1'b0, 32'd0, 32'hCAFE_0001, e, k);
    send_rq(32'h1000_0004, 1'b0, 32'd0, en, we_o, ad, mv);
    total++; if (we_o !== 1'b0) begin bad++; $display("FAIL mmio_ram_we got=%b exp=0", we_o); end
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (mmio_req_valid !== 1'b1) begin bad++; $display("FAIL mmio_valid cyc=%0d got=%b exp=1", i, mmio_req_valid); end
      total++; if (mmio_req_addr !== 32'h1000_0004) begin bad++; $display("FAIL mmio_addr cyc=%0d got=%h exp=10000004", i, mmio_req_addr); end
      total++; if (mmio_req_we !== 1'b0) begin bad++; $display("FAIL mmio_we cyc=%0d got=%b exp=0", i, mmio_req_we); end
      @(negedge clk);
    end
    mmio_req_ready = 1'b1;
    @(negedge clk);
    mmio_req_ready = 1'b0;
    #1;
    total++; if (mmio_req_valid !== 1'b0) begin bad++; $display("FAIL mmio_valid_after_ready got=%b exp=0", mmio_req_valid); end
    @(negedge clk);
    @(negedge clk);
    mmio_rsp_valid = 1'b1;
    mmio_rsp_data = 32'hCAFE_0001;
    @(negedge clk);
    mmio_rsp_valid = 1'b0;
    mmio_rsp_data = 32'h0;
    wait_rsp(8, got, data, lat);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL mmio_rsp_seen got=%b exp=1", got); end
    total++; if (data !== e) begin bad++; $display("FAIL mmio_rsp_data got=%h exp=%h", data, e); end
    total++; if (err !== exp_err) begin bad++; $display("FAIL mmio_err got=%b exp=%b", err, exp_err); end
  endtask

  task automatic test_timeout_race;
    logic en, we_o, mv, got;
    logic [7:0] ad;
    logic [31:0] e, data;
    int k, lat;
    model_rq(32'h1000_0010, 1'b0, 32'd0, 32'hCAFE_0002, e, k);
    send_rq(32'h1000_0010, 1'b0, 32'd0, en, we_o, ad, mv);
    mmio_req_ready = 1'b1;
    @(negedge clk);
    mmio_req_ready = 1'b0;
    repeat (TMO - 2) @(negedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL race_busy_before got=%b exp=1", busy); end
    total++; if (rs_en !== 1'b0) begin bad++; $display("FAIL race_rs_en_before got=%b exp=0", rs_en); end
    mmio_rsp_valid = 1'b1;
    mmio_rsp_data = 32'hCAFE_0002;
    @(negedge clk);
    mmio_rsp_valid = 1'b0;
    wait_rsp(4, got, data, lat);
    total++; if (data !== e) begin bad++; $display("FAIL race_data got=%h exp=%h", data, e); end
    total++; if (err !== exp_err) begin bad++; $display("FAIL race_err got=%b exp=%b", err, exp_err); end
  endtask

  task automatic test_timeout;
    logic en, we_o, mv, got;
    logic [7:0] ad;
    logic [31:0] data;
    int lat, cnt;
    send_rq(32'h1000_0020, 1'b0, 32'd0, en, we_o, ad, mv);
    exp_err = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!mmio_req_valid) break;
      cnt++;
      @(negedge clk);
    end
    total++; if (cnt !== TMO) begin bad++; $display("FAIL tmo_valid_cycles got=%0d exp=%0d", cnt, TMO); end
    wait_rsp(4, got, data, lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL tmo_rsp_latency got=%0d exp=0", lat); end
    total++; if (data !== ERRD) begin bad++; $display("FAIL tmo_data got=%h exp=%h", data, ERRD); end
    total++; if (err !== exp_err) begin bad++; $display("FAIL tmo_err got=%b exp=%b", err, exp_err); end
  endtask

  task automatic test_async_reset;
    logic en, we_o, mv, got;
    logic [7:0] ad;
    logic [31:0] e, data;
    int k, lat;
    send_rq(32'h1000_0008, 1'b0, 32'd0, en, we_o, ad, mv);
    mmio_req_ready = 1'b1;
    @(negedge clk);
    mmio_req_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    dropped++;
    exp_err = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL arst_err got=%b exp=0", err); end
    total++; if (mmio_req_addr !== 32'd0) begin bad++; $display("FAIL arst_mmio_addr got=%h exp=0", mmio_req_addr); end
    total++; if (rs_data !== 32'd0) begin bad++; $display("FAIL arst_rs_data got=%h exp=0", rs_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mmio_rsp_valid = 1'b1;
    mmio_rsp_data = 32'h5555_AAAA;
    @(negedge clk);
    mmio_rsp_valid = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stale_rsp_busy got=%b exp=0", busy); end
    total++; if (rs_en !== 1'b0) begin bad++; $display("FAIL stale_rsp_rs_en got=%b exp=0", rs_en); end
    model_rq(32'h10, 1'b0, 32'd0, 32'd0, e, k);
    send_rq(32'h10, 1'b0, 32'd0, en, we_o, ad, mv);
    wait_rsp(8, got, data, lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL arst_ram_latency got=%0d exp=0", lat); end
    total++; if (data !== e) begin bad++; $display("FAIL arst_ram_data got=%h exp=%h", data, e); end
  endtask

  task automatic test_unmapped;
    logic en, we_o, mv, got;
    logic [7:0] ad;
    logic [31:0] e, data;
    int k, lat;
    model_rq(32'h2000_0000, 1'b1, 32'h0BAD_F00D, 32'd0, e, k);
    send_rq(32'h2000_0000, 1'b1, 32'h0BAD_F00D, en, we_o, ad, mv);
    total++; if (we_o !== 1'b0) begin bad++; $display("FAIL unmap_ram_we got=%b exp=0", we_o); end
    total++; if (mv !== 1'b0) begin bad++; $display("FAIL unmap_mmio_valid got=%b exp=0", mv); end
    wait_rsp(8, got, data, lat);
    total++; if (data !== e) begin bad++; $display("FAIL unmap_data got=%h exp=%h", data, e); end
    total++; if (err !== exp_err) begin bad++; $display("FAIL unmap_err got=%b exp=%b", err, exp_err); end
    model_rq(32'h20, 1'b0, 32'd0, 32'd0, e, k);
    send_rq(32'h20, 1'b0, 32'd0, en, we_o, ad, mv);
    wait_rsp(8, got, data, lat);
    total++; if (data !== e) begin bad++; $display("FAIL unmap_next_ram_data got=%h exp=%h", data, e); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL unmap_err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_random;
    logic en, we_o, mv, got, w;
    logic [7:0] ad;
    logic [31:0] a, d, md, e, data;
    int k, lat, sel;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 2);
      case (sel)
        0:       a = 32'($urandom_range(0, 32'h3FF));
        1:       a = 32'h1000_0000 + 32'($urandom_range(0, 32'hFFF));
        default: a = 32'($urandom_range(32'h400, 32'h0FFF_FFFF));
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      md = $urandom;
      model_rq(a, w, d, md, e, k);
      exp_q.push_back(e);
      rs_rdy = 1'($urandom_range(0, 1));
      send_rq(a, w, d, en, we_o, ad, mv);
      total++; if (en !== 1'b1) begin bad++; $display("FAIL rnd_rq_en n=%0d got=%b exp=1", n, en); end
      total++; if (we_o !== (k == 0 && w)) begin bad++; $display("FAIL rnd_ram_we n=%0d a=%h got=%b", n, a, we_o); end
      if (k == 0) begin
        total++; if (ad !== a[9:2]) begin bad++; $display("FAIL rnd_ram_addr n=%0d got=%h exp=%h", n, ad, a[9:2]); end
      end
      total++; if (mv !== (k == 1)) begin bad++; $display("FAIL rnd_mmio_valid n=%0d a=%h got=%b", n, a, mv); end
      if (k == 1) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        total++; if ({mmio_req_addr, mmio_req_we, mmio_req_wdata} !== {a, w, d}) begin
          bad++; $display("FAIL rnd_mmio_fields n=%0d got=%h/%b/%h exp=%h/%b/%h", n,
                          mmio_req_addr, mmio_req_we, mmio_req_wdata, a, w, d);
        end
        mmio_req_ready = 1'b1;
        @(negedge clk);
        mmio_req_ready = 1'b0;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        mmio_rsp_valid = 1'b1;
        mmio_rsp_data = md;
        @(negedge clk);
        mmio_rsp_valid = 1'b0;
      end
      if (!rs_rdy) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rs_rdy = 1'b1;
      end
      wait_rsp(16, got, data, lat);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL rnd_rsp_seen n=%0d got=%b exp=1", n, got); end
      e = exp_q.pop_front();
      total++; if (data !== e) begin bad++; $display("FAIL rnd_rsp_data n=%0d a=%h w=%b got=%h exp=%h", n, a, w, data, e); end
    end
    total++; if (err !== exp_err) begin bad++; $display("FAIL rnd_err got=%b exp=%b", err, exp_err); end
  endtask

  initial begin
    rst_n = 1'b0;
    rq_rdy = 1'b0;
    rq_data = '0;
    rs_rdy = 1'b1;
    mmio_req_ready = 1'b0;
    mmio_rsp_valid = 1'b0;
    mmio_rsp_data = 32'd0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    test_reset();
    test_ram_wr_rd();
    test_backpressure();
    test_back_to_back();
    test_mmio_read();
    test_timeout_race();
    test_timeout();
    test_async_reset();
    test_unmapped();
    test_random();
    repeat (2) @(negedge clk);
    total++; if (n_rs !== n_rq - dropped) begin bad++; $display("FAIL rq_rs_pairing got=%0d responses exp=%0d", n_rs, n_rq - dropped); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_rq_sequencer.md
Name: mem_rq_sequencer

Overview:
- Sits between the processor core's memory get/put interface (65-bit request, 32-bit response) and the system's memory resources.
- Accepts one request at a time and decodes its address into on-chip RAM, an MMIO window, or unmapped.
- Sequences the synchronous-read RAM, or a valid/ready MMIO port with timeout, then returns exactly one response per request, honouring response backpressure.

Parameters:
- LGSZW, 8, log2 of RAM depth in 32-bit words
- MMIO_BASE, 32'h1000_0000, MMIO window byte base; must be aligned to 2^MMIO_LGSZ
- MMIO_LGSZ, 12, log2 of MMIO window size in bytes
- TIMEOUT_CYC, 255, max cycles in MMIO states before an error response (1..65535)
- ERR_DATA, 32'hDEAD_BEEF, response data for unmapped or timed-out accesses

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- rq_rdy  in  1  core has a request available (RDY of core's request get)
- rq_en  out  1  request accepted this cycle (EN of core's request get)
- rq_data  in  65  request: [64:33] byte address, [32] write, [31:0] write data
- rs_rdy  in  1  core can take a response
- rs_en  out  1  response delivered this cycle
- rs_data  out  32  response data
- ram_addr  out  LGSZW  RAM word address
- ram_we  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid one cycle after address
- mmio_req_valid  out  1  MMIO request valid
- mmio_req_ready  in  1  MMIO request accepted
- mmio_req_addr  out  32  MMIO byte address
- mmio_req_we  out  1  MMIO write
- mmio_req_wdata  out  32  MMIO write data
- mmio_rsp_valid  in  1  MMIO response (one-cycle pulse)
- mmio_rsp_data  in  32  MMIO response data
- busy  out  1  state != IDLE
- err  out  1  sticky: an unmapped or timed-out access occurred; cleared only by reset

Behaviour:
- Reset (async, RST_N low): state=IDLE; all registered outputs, err, timeout counter and response register are 0. A request in flight is dropped. RAM contents are not touched.
- Decode (combinational, on rq_data address A):
  - RAM if A>>(2+LGSZW)==0.
  - MMIO if A>>MMIO_LGSZ == MMIO_BASE>>MMIO_LGSZ.
  - Otherwise unmapped. RAM decode takes priority on overlap.
  - Address bits [1:0] are ignored (word access only).
- rq_en = rq_rdy && state==IDLE (combinational).
- ram_addr = A[LGSZW+1:2] (combinational).
- ram_wdata = rq_data[31:0].
- ram_we = rq_en && RAM && write.
- States and transitions:
  - IDLE: on rq_en go to RAM_RD (RAM), MMIO_REQ (MMIO) or RESP (unmapped). Unmapped loads rsp_q=ERR_DATA and sets err; an unmapped write has no side effects.
  - RAM_RD: rs_data = write ? 0 : ram_rdata, and rs_en = rs_rdy. If rs_rdy, go to IDLE (request-to-response latency 1 cycle). Otherwise latch that value into rsp_q and go to RESP.
  - MMIO_REQ: mmio_req_valid=1, with addr/we/wdata registered at accept and held stable. On mmio_req_ready, go to MMIO_RSP.
  - MMIO_RSP: on mmio_rsp_valid, rsp_q = we ? 0 : mmio_rsp_data, go to RESP.
  - RESP: rs_data=rsp_q, rs_en=rs_rdy. On rs_rdy, go to IDLE.
- Back-to-back: the earliest next rq_en is the cycle after rs_en.
- Timeout: counter cleared on entry to MMIO_REQ and incremented each cycle in MMIO_REQ/MMIO_RSP. When it reaches TIMEOUT_CYC without completion: rsp_q=ERR_DATA, err=1, go to RESP, mmio_req_valid drops. If mmio_rsp_valid coincides with the timeout cycle, the response wins and err is not set.
- mmio_rsp_valid outside MMIO_RSP is ignored.
- rs_data outside RAM_RD/RESP is 0.
- Exactly one rs_en per rq_en; no response without a request.

Decomposition:
- Package mem_ctl_pkg:
  - state enum {IDLE, RAM_RD, MMIO_REQ, MMIO_RSP, RESP}
  - region enum {REG_RAM, REG_MMIO, REG_NONE}
  - request field constants: RQ_ADDR_MSB=64, RQ_ADDR_LSB=33, RQ_WE=32, RQ_DATA_MSB=31
  - RQ_W=65
- One natural sub-module: mem_region_decode (combinational address to region, parameterised by LGSZW/MMIO_BASE/MMIO_LGSZ). It is reused by the system top for LED/debug decode.

Test Plan:
- RAM write then read: write A=0x0000_0010, D=0x1234_5678, with rs_rdy=1 -> ram_we pulses with ram_addr=4, response 0 one cycle later. Then read A=0x10 -> rs_en one cycle after rq_en, rs_data=0x1234_5678.
- Backpressure: RAM read with rs_rdy=0 for 5 cycles -> rs_en stays 0, busy=1, rq_en=0 throughout. rs_rdy rises -> rs_en same cycle with unchanged data.
- MMIO read: A=0x1000_0004, mmio_req_ready delayed 3 cycles, rsp_valid 2 cycles later with 0xCAFE_0001 -> mmio_req fields stable while valid; response 0xCAFE_0001; err=0.
- Unmapped write: A=0x2000_0000 -> no ram_we, no mmio_req_valid; response 0xDEAD_BEEF; err=1 and stays 1 after later good accesses.
- Timeout: MMIO read, mmio_req_ready never asserted, TIMEOUT_CYC=255 -> mmio_req_valid drops after 255 cycles; response 0xDEAD_BEEF; err=1. Repeat with rsp_valid on the timeout cycle -> MMIO data returned, err=0.
- Async reset mid-MMIO_RSP -> outputs go to 0 immediately with no clock edge. After release, a RAM read completes normally and a stale mmio_rsp_valid is ignored.
